// File: rtl/aux_uart_rx_fifo_if.sv
// MCU-side read/status bundle of the aux UART receive FIFO.
// Carries parity_err only when AUX_UART_RX_PARITY_EN is defined.
interface aux_uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             rd_en;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic [CNT_W-1:0] fifo_count;
    logic             clr_err;
    logic             frame_err;
    logic             overrun;
`ifdef AUX_UART_RX_PARITY_EN
    logic             parity_err;

    modport master (output rd_en, clr_err,
                    input  rd_data, rd_valid, fifo_count, frame_err, overrun, parity_err);
    modport slave  (input  rd_en, clr_err,
                    output rd_data, rd_valid, fifo_count, frame_err, overrun, parity_err);
`else
    modport master (output rd_en, clr_err,
                    input  rd_data, rd_valid, fifo_count, frame_err, overrun);
    modport slave  (input  rd_en, clr_err,
                    output rd_data, rd_valid, fifo_count, frame_err, overrun);
`endif
endinterface

// File: rtl/aux_uart_rx_fifo.sv
// Aux UART receiver: 2-flop rx synchroniser, 8N1 deserialiser, show-ahead byte FIFO, sticky errors.
// Optional 8E1 parity checking is enabled by defining AUX_UART_RX_PARITY_EN.
module aux_uart_rx_fifo #(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int BAUD_RATE     = 115200,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   rx,
    aux_uart_rx_fifo_if.slave      bus
);
    localparam int DIV   = (CLK_FREQUENCY + BAUD_RATE / 2) / BAUD_RATE;
    localparam int HALF  = DIV / 2;
    localparam int CW    = $clog2(DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef AUX_UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_e;

    function automatic logic parity8(input logic [7:0] d);
        return ^d;
    endfunction

    state_e            state_q, state_d;
    logic              rx_meta_q, rxs_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              expire_s, push_s, frame_set_s;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [7:0]        rd_data_q, head_d;
    logic              rd_valid_q, frame_err_q, overrun_q;
    logic              pop_s, full_s, wr_s, ovr_set_s;
`ifdef AUX_UART_RX_PARITY_EN
    logic              par_bad_q, par_bad_d, par_set_s, parity_err_q;
`endif

    // Receive FSM: next state, bit timing and byte assembly
    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push_s      = 1'b0;
        frame_set_s = 1'b0;
        expire_s    = (cnt_q == '0);
`ifdef AUX_UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
        par_set_s   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rxs_q) begin
                    cnt_d   = CW'(HALF - 1);
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (expire_s && rxs_q) begin
                    state_d = ST_IDLE;
                end else if (expire_s) begin
                    cnt_d     = CW'(DIV - 1);
                    bit_idx_d = 3'd0;
`ifdef AUX_UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (expire_s) begin
                    shift_d   = {rxs_q, shift_q[7:1]};
                    cnt_d     = CW'(DIV - 1);
                    bit_idx_d = bit_idx_q + 3'd1;
`ifdef AUX_UART_RX_PARITY_EN
                    state_d   = (bit_idx_q == 3'd7) ? ST_PARITY : ST_DATA;
`else
                    state_d   = (bit_idx_q == 3'd7) ? ST_STOP : ST_DATA;
`endif
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef AUX_UART_RX_PARITY_EN
            ST_PARITY: begin
                if (expire_s) begin
                    par_set_s = (rxs_q != parity8(shift_q));
                    par_bad_d = par_set_s;
                    cnt_d     = CW'(DIV - 1);
                    state_d   = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (expire_s && rxs_q) begin
`ifdef AUX_UART_RX_PARITY_EN
                    push_s  = ~par_bad_q;
`else
                    push_s  = 1'b1;
`endif
                    state_d = ST_IDLE;
                end else if (expire_s) begin
                    frame_set_s = 1'b1;
                    state_d     = ST_WAIT_HIGH;
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_WAIT_HIGH: begin
                state_d = rxs_q ? ST_IDLE : ST_WAIT_HIGH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO control; a full FIFO still accepts a push when a pop frees a slot that cycle
    always_comb begin
        pop_s     = bus.rd_en & rd_valid_q;
        full_s    = (count_q == CNT_W'(FIFO_DEPTH));
        wr_s      = push_s & (~full_s | pop_s);
        ovr_set_s = push_s & full_s & ~pop_s;
        wr_ptr_d  = wr_s  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CNT_W'(wr_s) - CNT_W'(pop_s);
        head_d    = (wr_s && (wr_ptr_q == rd_ptr_d)) ? shift_q : mem_q[rd_ptr_d];
    end

    // Synchroniser, FSM, FIFO pointers and sticky flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef AUX_UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx;
            rxs_q       <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= (count_d != '0);
            rd_data_q   <= head_d;
            frame_err_q <= frame_set_s | (frame_err_q & ~bus.clr_err);
            overrun_q   <= ovr_set_s   | (overrun_q   & ~bus.clr_err);
`ifdef AUX_UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= par_set_s | (parity_err_q & ~bus.clr_err);
`endif
        end
    end

    // Byte storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.fifo_count = count_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
`ifdef AUX_UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif
endmodule

// File: doc/aux_uart_rx_fifo.md
Name: aux_uart_rx_fifo

Overview:
- Receive front end for the auxiliary UART pin, sitting between the board-level rx pin and the MCU's aux UART input.
- Synchronises rx, deserialises 8N1 frames at a fixed baud rate, and buffers received bytes in a show-ahead FIFO.
- Exposes a read port to the MCU-side register logic, plus sticky frame-error and overrun flags.

Parameters:
- CLK_FREQUENCY, 50000000: clk frequency in Hz.
- BAUD_RATE, 115200: line rate in baud.
- FIFO_DEPTH, 16: byte entries; must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- rx  input  1  asynchronous serial line, idle high
- rd_en  input  1  pop request; honoured only when rd_valid=1
- rd_data  output  8  head-of-FIFO byte; valid while rd_valid=1
- rd_valid  output  1  FIFO non-empty
- fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held
- clr_err  input  1  clears frame_err and overrun
- frame_err  output  1  sticky: stop bit sampled low
- overrun  output  1  sticky: byte dropped because FIFO was full

Behaviour:
- Clock and reset: clk and reset_n (asynchronous, active-low) drive all flops.
- Reset values:
  - Synchroniser flops: 1.
  - rd_valid, fifo_count, frame_err, overrun: 0.
  - rd_data: 0.
  - FSM: IDLE.
- Bit period: DIV = (CLK_FREQUENCY + BAUD_RATE/2) / BAUD_RATE, computed at elaboration. Example: 50 MHz / 115200 gives 434. Half-period HALF = DIV/2.
- Synchroniser: rx passes through 2 flops giving rxs. All decisions use rxs only.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rxs=0, load the bit counter with HALF-1 and go to START.
  - START: on counter expiry, sample rxs.
    - rxs=1: glitch; return to IDLE and push nothing.
    - rxs=0: load DIV-1, clear the bit index, go to DATA.
  - DATA: on each expiry, shift rxs into the shift register LSB-first and reload DIV-1. After bit 7 is sampled, go to STOP.
  - STOP: on expiry, sample rxs.
    - rxs=1: push the byte and go to IDLE.
    - rxs=0: set frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then go to IDLE. A break condition therefore yields exactly one frame_err and no bytes.
- Push latency: the push happens in the cycle of the stop-bit sample. fifo_count and rd_valid update on the next clk edge.
- FIFO: show-ahead. rd_data always reflects the head entry, registered from storage.
  - A pop (rd_en & rd_valid) advances the head; the new head appears on the next edge.
  - rd_en while empty: ignored, no underflow, count stays 0.
- Full FIFO with a push:
  - Without a pop in the same cycle: the byte is dropped, overrun is set, contents are unchanged.
  - With a simultaneous pop: both take effect, count stays FIFO_DEPTH, overrun is not set.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH inclusive.
- Sticky flags:
  - clr_err=1 clears both flags on the next edge.
  - If a set event and clr_err occur in the same cycle, the set wins.
- Reset mid-frame: all state returns to reset values immediately. The FIFO is emptied. A partially received byte is never pushed.

Optional Feature:
- Macro: AUX_UART_RX_PARITY_EN.
- When defined:
  - An extra PARITY state sits between DATA and STOP and samples one bit after bit 7, DIV cycles later.
  - Frame is 8E1: expected parity = XOR of the 8 data bits.
  - Adds output parity_err (1 bit, sticky, reset 0, cleared by clr_err).
  - On mismatch, parity_err is set and the byte is discarded. The stop bit is still checked and can set frame_err as well.
- When undefined:
  - Format is 8N1.
  - parity_err port is absent and no PARITY state exists.

Test Plan (CLK_FREQUENCY=1000000, BAUD_RATE=100000, so DIV=10; FIFO_DEPTH=4):
- Send 0xA5 as 8N1 -> rd_valid=1 and rd_data=0xA5 within 2 cycles of the stop-bit mid-sample; fifo_count=1; pulse rd_en -> count 0, rd_valid=0.
- 3-cycle low glitch on idle rx -> no push; FSM back in IDLE; flags remain 0.
- Send 0x3C with stop bit forced low, then rx held low for 50 cycles -> frame_err=1, fifo_count=0, exactly one error event; rx high then 0x55 -> 0x55 received normally.
- Send 5 bytes 0x01..0x05 without reading -> fifo_count=4, overrun=1, pops yield 0x01..0x04; clr_err -> overrun=0.
- FIFO full, rd_en asserted in the stop-sample cycle of byte 0x77 -> count stays 4, overrun=0, last entry is 0x77.
- Assert reset_n=0 mid-DATA with 2 bytes buffered -> fifo_count=0, rd_valid=0, flags 0; next frame 0x81 is received correctly. With AUX_UART_RX_PARITY_EN, send 0x81 with odd parity bit -> parity_err=1, no push.
